// File: rtl/iram_ctrl.sv
// ============================================================================
//  Module   : iram_ctrl
//  Purpose  : Bus-side controller in front of the instruction RAM. Converts a
//             valid/ready memory request (fetch or data load/store) into IRAM
//             port signals, sequences the RAM's 1-cycle read latency and
//             returns a one-cycle mem_ready pulse. Accesses outside the IRAM
//             window complete with mem_error instead of touching the RAM.
//  Optional : `define IRAM_ALIGN_CHECK_EN to reject misaligned or malformed
//             byte-strobe requests with mem_error.
//  Ports    : clk, reset (async active-low)
//             mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb  - request in
//             mem_ready/mem_error/mem_rdata                     - response out
//             iram_wen/iram_waddr/iram_raddr/iram_wdata/iram_wstrb - RAM side
//             iram_rdata - RAM read data, 1 cycle after raddr sampled
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iram_ctrl #(
    parameter int          IRAM_DEPTH = 12,
    parameter logic [31:0] IRAM_BASE  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic [31:0]           mem_rdata,
    output logic                  iram_wen,
    output logic [IRAM_DEPTH-1:0] iram_waddr,
    output logic [IRAM_DEPTH-1:0] iram_raddr,
    output logic [31:0]           iram_wdata,
    output logic [3:0]            iram_wstrb,
    input  logic [31:0]           iram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_WAIT  = 2'd1,
        S_WR_DONE  = 2'd2,
        S_ERR_RESP = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IRAM_DEPTH-1:0] w_index;
    logic                  w_hit;
    logic                  w_is_write;
    logic                  w_align_bad;
    logic                  w_accept;
    logic                  w_reject;

    // Hit check uses the full upper address before truncation, so addresses
    // just above the window never alias back into it.
    assign w_index    = mem_addr[IRAM_DEPTH+1:2];
    assign w_hit      = (mem_addr[31:IRAM_DEPTH+2] == IRAM_BASE[31:IRAM_DEPTH+2]);
    assign w_is_write = (mem_wstrb != 4'b0000);

`ifdef IRAM_ALIGN_CHECK_EN
    // Only naturally aligned byte, halfword and word accesses are legal.
    always_comb begin
        w_align_bad = 1'b0;
        case (mem_wstrb)
            4'b0000: w_align_bad = (mem_addr[1:0] != 2'd0);
            4'b0001: w_align_bad = (mem_addr[1:0] != 2'd0);
            4'b0010: w_align_bad = (mem_addr[1:0] != 2'd1);
            4'b0100: w_align_bad = (mem_addr[1:0] != 2'd2);
            4'b1000: w_align_bad = (mem_addr[1:0] != 2'd3);
            4'b0011: w_align_bad = (mem_addr[1:0] != 2'd0);
            4'b1100: w_align_bad = (mem_addr[1:0] != 2'd2);
            4'b1111: w_align_bad = (mem_addr[1:0] != 2'd0);
            default: w_align_bad = 1'b1;
        endcase
    end
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^mem_addr[1:0];
    assign w_align_bad  = 1'b0;
`endif

    // Requests are only taken in IDLE; gating with reset keeps the RAM
    // strobes quiet while reset is asserted.
    assign w_accept = mem_valid && reset && (state_q == S_IDLE);
    assign w_reject = !w_hit || (mem_instr && w_is_write) || w_align_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_ready  = 1'b0;
        mem_error  = 1'b0;
        mem_rdata  = 32'h0;
        iram_wen   = 1'b0;
        iram_wstrb = 4'b0000;
        iram_waddr = w_index;
        iram_raddr = w_index;
        iram_wdata = mem_wdata;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        state_d = S_ERR_RESP;
                    end else if (w_is_write) begin
                        iram_wen   = 1'b1;
                        iram_wstrb = mem_wstrb;
                        state_d    = S_WR_DONE;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                mem_ready = 1'b1;
                mem_rdata = iram_rdata;
                state_d   = S_IDLE;
            end
            S_WR_DONE: begin
                mem_ready = 1'b1;
                state_d   = S_IDLE;
            end
            S_ERR_RESP: begin
                mem_ready = 1'b1;
                mem_error = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
